// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared sequencer state type and array timing helper
package tpu_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_PRELOAD,
    SEQ_LOAD,
    SEQ_STREAM,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_type;

  // Last row's partial sum leaves the array N-1 hops after the first row sees data.
  function automatic int seq_latency(input int matrix_width, input int mac_latency);
    return matrix_width - 1 + mac_latency;
  endfunction

endpackage

// File: rtl/mac_array_sequencer_valid_delay_line.sv
// rtl/mac_array_sequencer_valid_delay_line.sv - fixed-depth 1-bit valid shift register
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic delayed
);

  logic [DEPTH-1:0] stages;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stages <= '0;
        else     stages <= valid;
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stages <= '0;
        else     stages <= {stages[DEPTH-2:0], valid};
      end
    end
  endgenerate

  assign delayed = stages[DEPTH-1];

endmodule

// File: rtl/mac_array_sequencer.sv
// rtl/mac_array_sequencer.sv - weight-stationary pass sequencer for the MAC array
module mac_array_sequencer
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH  = 8,
  parameter int ADDRESS_WIDTH = 16,
  parameter int LENGTH_WIDTH  = 16,
  parameter int MAC_LATENCY   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] weight_base,
  input  logic [ADDRESS_WIDTH-1:0] data_base,
  input  logic [LENGTH_WIDTH-1:0]  length,
  output logic                     busy,
  output logic                     done,
  output logic                     weight_rd_en,
  output logic [ADDRESS_WIDTH-1:0] weight_rd_addr,
  output logic                     data_rd_en,
  output logic [ADDRESS_WIDTH-1:0] data_rd_addr,
  output logic                     preload_weight,
  output logic                     load_weight,
  output logic                     enable,
  output logic                     result_valid
);

  localparam int LATENCY = seq_latency(MATRIX_WIDTH, MAC_LATENCY);
  localparam int K_WIDTH = $clog2(MATRIX_WIDTH);
  localparam int D_WIDTH = $clog2(LATENCY + 1);
  localparam logic [K_WIDTH-1:0] K_LAST   = K_WIDTH'(MATRIX_WIDTH - 1);
  localparam logic [K_WIDTH-1:0] K_PENULT = K_WIDTH'(MATRIX_WIDTH - 2);
  localparam logic [D_WIDTH-1:0] D_LAST   = D_WIDTH'(LATENCY - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STEP = ADDRESS_WIDTH'(1);
  localparam logic [LENGTH_WIDTH-1:0]  LEN_ONE   = LENGTH_WIDTH'(1);
  localparam logic [LENGTH_WIDTH-1:0]  LEN_TWO   = LENGTH_WIDTH'(2);

  seq_state_type            state;
  logic [K_WIDTH-1:0]       k;
  logic [LENGTH_WIDTH-1:0]  j;
  logic [D_WIDTH-1:0]       drain;
  logic [LENGTH_WIDTH-1:0]  len;

  // Outputs are registered for the state being entered, so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SEQ_IDLE;
      k              <= '0;
      j              <= '0;
      drain          <= '0;
      len            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      weight_rd_en   <= 1'b0;
      weight_rd_addr <= '0;
      data_rd_en     <= 1'b0;
      data_rd_addr   <= '0;
      preload_weight <= 1'b0;
      load_weight    <= 1'b0;
      enable         <= 1'b0;
    end else begin
      done           <= 1'b0;
      weight_rd_en   <= 1'b0;
      data_rd_en     <= 1'b0;
      preload_weight <= 1'b0;
      load_weight    <= 1'b0;
      enable         <= 1'b0;
      case (state)
        SEQ_IDLE: if (start) begin
          state          <= SEQ_FETCH;
          busy           <= 1'b1;
          len            <= length;
          weight_rd_addr <= weight_base;
          data_rd_addr   <= data_base;
          weight_rd_en   <= 1'b1;
        end
        SEQ_FETCH: begin
          state          <= SEQ_PRELOAD;
          k              <= '0;
          preload_weight <= 1'b1;
          weight_rd_en   <= 1'b1;
          weight_rd_addr <= weight_rd_addr + ADDR_STEP;
        end
        SEQ_PRELOAD: if (k == K_LAST) begin
          state       <= SEQ_LOAD;
          load_weight <= 1'b1;
          data_rd_en  <= (len != '0);
        end else begin
          k              <= k + K_WIDTH'(1);
          preload_weight <= 1'b1;
          if (k != K_PENULT) begin
            weight_rd_en   <= 1'b1;
            weight_rd_addr <= weight_rd_addr + ADDR_STEP;
          end
        end
        SEQ_LOAD: if (len == '0) begin
          state <= SEQ_DONE;
          done  <= 1'b1;
        end else begin
          state  <= SEQ_STREAM;
          j      <= '0;
          enable <= 1'b1;
          if (len != LEN_ONE) begin
            data_rd_en   <= 1'b1;
            data_rd_addr <= data_rd_addr + ADDR_STEP;
          end
        end
        SEQ_STREAM: if (j == len - LEN_ONE) begin
          state <= SEQ_DRAIN;
          drain <= '0;
        end else begin
          j      <= j + LEN_ONE;
          enable <= 1'b1;
          if (j != len - LEN_TWO) begin
            data_rd_en   <= 1'b1;
            data_rd_addr <= data_rd_addr + ADDR_STEP;
          end
        end
        SEQ_DRAIN: if (drain == D_LAST) begin
          state <= SEQ_DONE;
          done  <= 1'b1;
        end else begin
          drain <= drain + D_WIDTH'(1);
        end
        default: begin
          state <= SEQ_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH(LATENCY)
  ) u_valid_delay_line (
    .clk    (clk),
    .rst    (rst),
    .valid  (enable),
    .delayed(result_valid)
  );

endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb/tb_mac_array_sequencer.sv - directed scoreboard bench for mac_array_sequencer
module tb_mac_array_sequencer;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int LW  = 16;
  localparam int ML  = 3;
  localparam int LAT = N - 1 + ML;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] weight_base = '0;
  logic [AW-1:0] data_base = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, weight_rd_en, data_rd_en;
  logic          preload_weight, load_weight, enable, result_valid;
  logic [AW-1:0] weight_rd_addr, data_rd_addr;

  always #5 clk = ~clk;

  mac_array_sequencer #(
    .MATRIX_WIDTH (N),
    .ADDRESS_WIDTH(AW),
    .LENGTH_WIDTH (LW),
    .MAC_LATENCY  (ML)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .weight_base   (weight_base),
    .data_base     (data_base),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .weight_rd_en  (weight_rd_en),
    .weight_rd_addr(weight_rd_addr),
    .data_rd_en    (data_rd_en),
    .data_rd_addr  (data_rd_addr),
    .preload_weight(preload_weight),
    .load_weight   (load_weight),
    .enable        (enable),
    .result_valid  (result_valid)
  );

  typedef struct {
    logic [7:0]    ctl;
    logic [AW-1:0] wa;
    logic [AW-1:0] da;
  } exp_t;

  exp_t          exp_q[$];
  int            psum_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [AW-1:0] cur_db = '0;
  logic [AW-1:0] data_q = '0;

  // Data buffer model: word at address a holds (a - base + 1), one cycle read latency.
  always @(posedge clk) begin
    if (data_rd_en) data_q <= data_rd_addr - cur_db + AW'(1);
  end

  function automatic logic [7:0] obs_ctl();
    return {busy, done, weight_rd_en, preload_weight, load_weight, data_rd_en, enable, result_valid};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input logic [AW-1:0] wb, input logic [AW-1:0] db,
                          input logic [LW-1:0] len, input int inject_at);
    int   total;
    int   rv_count;
    int   acc;
    int   j_seen;
    int   last_en;
    exp_t e;
    total   = N + 3 + int'(len) + ((len != 0) ? LAT : 0);
    last_en = N + 2 + int'(len);
    for (int c = 1; c <= total + 1; c++) begin
      e.ctl = {c <= total, c == total, c <= N, (c >= 2) && (c <= N + 1), c == N + 2,
               (len != 0) && (c >= N + 2) && (c <= N + 1 + int'(len)),
               (c >= N + 3) && (c <= last_en),
               (c >= N + 3 + LAT) && (c <= last_en + LAT)};
      e.wa  = wb + AW'(c - 1);
      e.da  = db + AW'(c - N - 2);
      exp_q.push_back(e);
    end
    weight_base = wb;
    data_base   = db;
    length      = len;
    cur_db      = db;
    start       = 1'b1;
    step();
    start    = 1'b0;
    rv_count = 0;
    acc      = 0;
    j_seen   = 0;
    psum_q.delete();
    for (int c = 1; c <= total + 1; c++) begin
      e = exp_q.pop_front();
      check($sformatf("ctl@%0d", c), 64'(obs_ctl()), 64'(e.ctl));
      if (e.ctl[5]) check($sformatf("weight_addr@%0d", c), 64'(weight_rd_addr), 64'(e.wa));
      if (e.ctl[2]) check($sformatf("data_addr@%0d", c), 64'(data_rd_addr), 64'(e.da));
      if (enable) begin
        check($sformatf("data_in@%0d", c), 64'(data_q), 64'(j_seen + 1));
        psum_q.push_back(3 * int'(data_q));
        j_seen++;
      end
      if (result_valid) begin
        if (psum_q.size() > 0) acc += psum_q.pop_front();
        rv_count++;
      end
      if (c == inject_at) begin
        start       = 1'b1;
        weight_base = 16'h0BAD;
        data_base   = 16'h0BAD;
        length      = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (c <= total) step();
    end
    check("result_valid_count", 64'(rv_count), 64'(len));
    check("accumulated_sum", 64'(acc), 64'(3 * int'(len) * (int'(len) + 1) / 2));
  endtask

  initial begin : main
    int done_seen;
    #2 rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", {obs_ctl(), weight_rd_addr, data_rd_addr}, 64'd0);
    rst = 1'b0;

    run_pass(16'h0010, 16'h0040, 16'd5, 0);
    run_pass(16'h0020, 16'h0080, 16'd0, 0);
    run_pass(16'hFFFE, 16'h0100, 16'd2, 0);
    run_pass(16'h0200, 16'hFFFF, 16'd3, 0);
    run_pass(16'h0030, 16'h0050, 16'd3, N + 4);
    run_pass(16'h0030, 16'h0050, 16'd3, 0);
    run_pass(16'h0040, 16'h0060, 16'd1, 0);

    weight_base = 16'h0070;
    data_base   = 16'h0090;
    length      = 16'd6;
    cur_db      = 16'h0090;
    start       = 1'b1;
    step();
    start = 1'b0;
    repeat (N + 4) step();
    check("enable_before_rst", 64'(enable), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {obs_ctl(), weight_rd_addr, data_rd_addr}, 64'd0);
    step();
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) done_seen++;
      step();
    end
    check("no_done_after_abort", 64'(done_seen), 64'd0);

    run_pass(16'h0000, 16'h0010, 16'd4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
